// File: rtl/pipe_reg_elastic.sv
// Elastic WIDTH x DEPTH register pipe with valid/ready, bubble collapsing and flush.
// Optional occupancy output enabled by PIPE_REG_ELASTIC_COUNT_EN.
`timescale 1ns/1ps
module pipe_reg_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_REG_ELASTIC_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_elastic: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] vin;
  logic [WIDTH-1:0] din [DEPTH];

  // rdy[k] is set when out_ready or any stage at or after k is empty
  always_comb begin
    logic full;
    full = 1'b1;
    rdy  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      full   = full & v[k];
      rdy[k] = out_ready | ~full;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    vin[0] = in_valid & in_ready;
    din[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      vin[k] = v[k-1];
      din[k] = d[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v[k] <= vin[k];
          if (vin[k]) d[k] <= din[k];
        end
      end
    end
  end

`ifdef PIPE_REG_ELASTIC_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic push;
  logic pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  a_count_max: assert property (
    @(posedge clk) disable iff (reset) int'(count) <= DEPTH
  );
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Randomised and directed bench for pipe_reg_elastic against a queue-based model.
// Each stored word carries a stage position; advance rules use occupancy counts.
`timescale 1ns/1ps
module tb_pipe_reg_elastic;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef PIPE_REG_ELASTIC_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] count;
`endif

  pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_REG_ELASTIC_COUNT_EN
    ,
    .count     (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } ent_t;

  ent_t             q[$];
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] last_out;
  int               checks;
  int               errors;
  int               edge_n;
  int               first_ov;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ovalid();
    return q.size() > 0 && q[0].pos == DEPTH - 1;
  endfunction

  function automatic bit m_iready(input logic ordy, input logic fl);
    return !fl && (ordy || q.size() < DEPTH);
  endfunction

  task automatic cyc(input logic iv, input logic [WIDTH-1:0] id,
                     input logic ordy, input logic fl);
    bit   push;
    bit   pop;
    bit   mov;
    int   p;
    int   above;
    ent_t e;
    ent_t nq[$];
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("in_ready", in_ready, m_iready(ordy, fl));
    chk("out_valid", out_valid, m_ovalid());
    chk("out_data", out_data, last_out);
`ifdef PIPE_REG_ELASTIC_COUNT_EN
    chk("count", count, q.size());
`endif
    if (out_valid && first_ov < 0) first_ov = edge_n;
    push = iv && m_iready(ordy, fl);
    pop  = m_ovalid() && ordy;
    if (pop) begin
      if (sb.size() == 0) chk("sb_nonempty", 0, 1);
      else chk("order", out_data, sb.pop_front());
    end
    if (fl) sb.delete();
    if (push) sb.push_back(id);
    nq = {};
    foreach (q[i]) begin
      if (i == 0 && pop) continue;
      if (fl) continue;
      p = q[i].pos;
      above = 0;
      foreach (q[j]) if (q[j].pos > p) above++;
      mov = (p < DEPTH - 1) && (ordy || above < DEPTH - 1 - p);
      e = q[i];
      if (mov) begin
        e.pos = p + 1;
        if (e.pos == DEPTH - 1) last_out = e.data;
      end
      nq.push_back(e);
    end
    if (push) begin
      e.data = id;
      e.pos  = 0;
      if (DEPTH == 1) last_out = id;
      nq.push_back(e);
    end
    q = nq;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic async_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    q.delete();
    sb.delete();
    last_out = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    checks    = 0;
    errors    = 0;
    edge_n    = 0;
    first_ov  = -1;
    last_out  = '0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // back-to-back streaming and latency
    first_ov = -1;
    e0 = edge_n;
    for (int i = 1; i <= 8; i++) cyc(1'b1, WIDTH'(i), 1'b1, 1'b0);
    drain();
    chk("latency", first_ov - (e0 + 1), DEPTH - 1);

    // backpressure fill, rejected word, release
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b1, 1'b0);
    drain();

    // bubble collapse
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b0, 1'b0);
    drain();

    // flush while full, then flush with simultaneous pop
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    cyc(1'b1, 32'h6, 1'b0, 1'b0);
    cyc(1'b1, 32'h7, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'(32'h50 + i), 1'b0, 1'b0);
    cyc(1'b1, 32'h9, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // full pipe with simultaneous pop and push
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'(32'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, WIDTH'(32'h70 + i), 1'b1, 1'b0);
    drain();

    // reset mid-stream with two words inside
    cyc(1'b1, 32'h81, 1'b0, 1'b0);
    cyc(1'b1, 32'h82, 1'b0, 1'b0);
    async_reset();
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom(),
          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
